// File: rtl/eta_eval_pkg.sv
// rtl/eta_eval_pkg.sv - shared FSM state and drain constant for the ETA sweep engine
package eta_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DRAIN_CYCLES = 3;

endpackage

// File: rtl/eta_error_evaluator_if.sv
// rtl/eta_error_evaluator_if.sv - control/result bundle of the ETA sweep engine
// ETA_EVAL_MAXERR_EN adds the max-error result signals.
interface eta_error_evaluator_if #(
  parameter int WIDTH = 8
);

  logic               start;
  logic               busy;
  logic               done;
  logic [2*WIDTH:0]   total_cases;
  logic [2*WIDTH:0]   error_cases;
  logic [3*WIDTH:0]   total_err_dist;
`ifdef ETA_EVAL_MAXERR_EN
  logic [WIDTH:0]     max_err_dist;
  logic [WIDTH-1:0]   max_err_a;
  logic [WIDTH-1:0]   max_err_b;

  modport master (
    output start,
    input  busy, done, total_cases, error_cases, total_err_dist,
    input  max_err_dist, max_err_a, max_err_b
  );

  modport slave (
    input  start,
    output busy, done, total_cases, error_cases, total_err_dist,
    output max_err_dist, max_err_a, max_err_b
  );
`else
  modport master (
    output start,
    input  busy, done, total_cases, error_cases, total_err_dist
  );

  modport slave (
    input  start,
    output busy, done, total_cases, error_cases, total_err_dist
  );
`endif

endinterface

// File: rtl/eta_adder_param.sv
// rtl/eta_adder_param.sv - combinational error-tolerant adder, SPLIT-bit inexact lower part
module eta_adder_param #(
  parameter int WIDTH = 8,
  parameter int SPLIT = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] upper;
  logic           force_ones;

  always_comb begin
    upper      = ({1'b0, a} >> SPLIT) + ({1'b0, b} >> SPLIT);
    sum        = upper << SPLIT;
    force_ones = 1'b0;
    // Scan the lower part MSB-first; the first generate position saturates everything below it.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i < SPLIT) begin
        if (a[i] & b[i]) begin
          force_ones = 1'b1;
        end
        sum[i] = force_ones | (a[i] ^ b[i]);
      end
    end
  end

endmodule

// File: rtl/eta_error_evaluator.sv
// rtl/eta_error_evaluator.sv - exhaustive ETA-vs-exact sweep engine with error accumulators
// ETA_EVAL_MAXERR_EN adds max-error tracking with the operands of its earliest occurrence.
module eta_error_evaluator
  import eta_eval_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SPLIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  eta_error_evaluator_if.slave  bus
);

  localparam int CW = 2 * WIDTH;
  localparam int TW = 2 * WIDTH + 1;
  localparam int DW = 3 * WIDTH + 1;

  state_t          state, state_nx;
  logic            accept;
  logic [CW-1:0]   cnt;
  logic            last_issued;
  logic [1:0]      drain_cnt;

  logic            v1, v2, v3;
  logic [WIDTH-1:0] a1, b1;
  logic [WIDTH:0]  approx_c, approx2, exact2;
  logic [WIDTH:0]  diff3;
  logic            nz3;

  logic [TW-1:0]   total_cases, error_cases;
  logic [DW-1:0]   total_err_dist;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      IDLE:  if (bus.start) begin
               state_nx = SWEEP;
               accept   = 1'b1;
             end
      SWEEP: if (last_issued) state_nx = DRAIN;
      DRAIN: if (drain_cnt == 2'(DRAIN_CYCLES - 1)) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_issued <= 1'b0;
      drain_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt         <= '0;
        last_issued <= 1'b0;
      end else if (state == SWEEP && !last_issued) begin
        cnt         <= cnt + CW'(1);
        last_issued <= (cnt == '1);
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
    end
  end

  eta_adder_param #(.WIDTH(WIDTH), .SPLIT(SPLIT)) u_eta (
    .a   (a1),
    .b   (b1),
    .sum (approx_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= (state == SWEEP) && !last_issued;
      v2 <= v1;
      v3 <= v2;
    end
    a1      <= cnt[CW-1:WIDTH];
    b1      <= cnt[WIDTH-1:0];
    approx2 <= approx_c;
    exact2  <= {1'b0, a1} + {1'b0, b1};
    diff3   <= (exact2 >= approx2) ? exact2 - approx2 : approx2 - exact2;
    nz3     <= (exact2 != approx2);
  end

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      total_cases    <= '0;
      error_cases    <= '0;
      total_err_dist <= '0;
    end else if (v3) begin
      total_cases    <= total_cases + TW'(1);
      error_cases    <= error_cases + TW'(nz3);
      total_err_dist <= total_err_dist + DW'(diff3);
    end
  end

  assign bus.busy           = (state == SWEEP) || (state == DRAIN);
  assign bus.done           = (state == DONE);
  assign bus.total_cases    = total_cases;
  assign bus.error_cases    = error_cases;
  assign bus.total_err_dist = total_err_dist;

`ifdef ETA_EVAL_MAXERR_EN
  logic [WIDTH-1:0] a2, b2, a3, b3;
  logic [WIDTH:0]   max_err_dist;
  logic [WIDTH-1:0] max_err_a, max_err_b;

  always_ff @(posedge clk) begin
    a2 <= a1;
    b2 <= b1;
    a3 <= a2;
    b3 <= b2;
  end

  // Strictly-greater update keeps the earliest pair on ties.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      max_err_dist <= '0;
      max_err_a    <= '0;
      max_err_b    <= '0;
    end else if (v3 && (diff3 > max_err_dist)) begin
      max_err_dist <= diff3;
      max_err_a    <= a3;
      max_err_b    <= b3;
    end
  end

  assign bus.max_err_dist = max_err_dist;
  assign bus.max_err_a    = max_err_a;
  assign bus.max_err_b    = max_err_b;
`endif

endmodule
